// File: rtl/imp_x_sub_ex_unit.sv
// Centring stage: buffers N signed samples, waits for the mean E[x], then streams x_i - E[x] in order.
// Optional build macro IMP_XC_SAT8_EN clamps the centred output to -127..127.
module imp_x_sub_ex_unit #(
  parameter int N = 8
) (
  input  logic       i_clk,
  input  logic       i_rstn,
  input  logic       i_valid,
  input  logic [7:0] i_x,
  output logic       o_in_ready,
  input  logic       i_Ex_done,
  input  logic [8:0] i_Ex,
  output logic       o_xc_valid,
  output logic [8:0] o_xc,
  output logic       o_xc_last,
  output logic       o_busy
);
  localparam int AW = $clog2(N);
  localparam logic [AW-1:0] LAST = AW'(N - 1);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_WAIT, S_OUT} state_t;

  state_t              r_state, w_next;
  logic [AW-1:0]       r_wr, r_rd;
  logic                r_ex_pend;
  logic signed [8:0]   r_ex;
  logic [7:0]          r_buf [N];
  logic                r_in_ready, r_xc_valid, r_xc_last, r_busy;
  logic signed [8:0]   r_xc;
  logic                w_acc;
  logic signed [8:0]   w_diff, w_xc;

  assign w_acc = i_valid && (r_state == S_IDLE || r_state == S_FILL);

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (i_valid) w_next = S_FILL;
      S_FILL: if (i_valid && r_wr == LAST) w_next = S_WAIT;
      S_WAIT: if (r_ex_pend || i_Ex_done) w_next = S_OUT;
      S_OUT:  if (r_rd == LAST) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Sample storage has no reset; contents are only read after a full fill.
  always_ff @(posedge i_clk) begin
    if (w_acc) r_buf[r_wr] <= i_x;
  end

  assign w_diff = $signed({r_buf[r_rd][7], r_buf[r_rd]}) - r_ex;

`ifdef IMP_XC_SAT8_EN
  assign w_xc = (w_diff > 9'sd127) ? 9'sd127 :
                (w_diff < -9'sd127) ? -9'sd127 : w_diff;
`else
  assign w_xc = w_diff;
`endif

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_wr       <= '0;
      r_rd       <= '0;
      r_ex_pend  <= 1'b0;
      r_ex       <= '0;
      r_in_ready <= 1'b1;
      r_xc_valid <= 1'b0;
      r_xc       <= '0;
      r_xc_last  <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      if (w_acc) r_wr <= r_wr + 1'b1;
      if (r_state == S_OUT) r_rd <= r_rd + 1'b1;
      // A mean arriving in WAIT is latched here too, so OUT always reads r_ex.
      if (i_Ex_done && r_state != S_OUT) begin
        r_ex      <= $signed(i_Ex);
        r_ex_pend <= 1'b1;
      end else if (r_state == S_OUT && r_rd == LAST) begin
        r_ex_pend <= 1'b0;
      end
      r_xc_valid <= (r_state == S_OUT);
      r_xc       <= (r_state == S_OUT) ? w_xc : 9'sd0;
      r_xc_last  <= (r_state == S_OUT) && (r_rd == LAST);
      r_busy     <= (w_next != S_IDLE);
      r_in_ready <= (w_next == S_IDLE) || (w_next == S_FILL);
    end
  end

  assign o_in_ready = r_in_ready;
  assign o_xc_valid = r_xc_valid;
  assign o_xc       = r_xc;
  assign o_xc_last  = r_xc_last;
  assign o_busy     = r_busy;
endmodule

// File: tb/tb_imp_x_sub_ex_unit.sv
// Directed bench for imp_x_sub_ex_unit (N=8): constant, ramp, extremes, early mean, dropped input, reset.
module tb_imp_x_sub_ex_unit;
  logic       i_clk, i_rstn, i_valid, i_Ex_done;
  logic [7:0] i_x;
  logic [8:0] i_Ex;
  logic       o_in_ready, o_xc_valid, o_xc_last, o_busy;
  logic [8:0] o_xc;

  int checks = 0;
  int errors = 0;
  int ev [8];

  imp_x_sub_ex_unit #(.N(8)) dut (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_valid(i_valid), .i_x(i_x),
    .o_in_ready(o_in_ready), .i_Ex_done(i_Ex_done), .i_Ex(i_Ex),
    .o_xc_valid(o_xc_valid), .o_xc(o_xc), .o_xc_last(o_xc_last), .o_busy(o_busy)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic push(input int v);
    i_valid = 1'b1;
    i_x     = 8'(v);
    tick();
    i_valid = 1'b0;
  endtask

  // Mean unit model: done pulse after `dly` idle cycles; leaves us one edge before first output.
  task automatic give_ex(input int v, input int dly);
    repeat (dly) tick();
    i_Ex_done = 1'b1;
    i_Ex      = 9'(v);
    tick();
    i_Ex_done = 1'b0;
  endtask

  // Expects first output visible now; returns during the o_xc_last cycle.
  task automatic run_out(input string tag);
    int g;
    for (int k = 0; k < 8; k++) begin
      g = $signed(o_xc);
      chk({tag, "_valid"}, int'(o_xc_valid), 1);
      chk({tag, "_xc"}, g, ev[k]);
      chk({tag, "_last"}, int'(o_xc_last), (k == 7) ? 1 : 0);
      chk({tag, "_rdy"}, int'(o_in_ready), (k == 7) ? 1 : 0);
      if (k < 7) tick();
    end
  endtask

  initial begin
    i_rstn = 1'b0; i_valid = 1'b0; i_x = '0; i_Ex_done = 1'b0; i_Ex = '0;
    repeat (2) tick();
    chk("rst_rdy", int'(o_in_ready), 1);
    chk("rst_busy", int'(o_busy), 0);
    chk("rst_valid", int'(o_xc_valid), 0);
    chk("rst_xc", int'(o_xc), 0);
    chk("rst_last", int'(o_xc_last), 0);
    i_rstn = 1'b1;
    tick();

    // Constant vector: 10 x8, Ex=10
    for (int k = 0; k < 8; k++) push(10);
    chk("const_wait_rdy", int'(o_in_ready), 0);
    chk("const_wait_busy", int'(o_busy), 1);
    give_ex(10, 1);
    chk("const_lat_valid", int'(o_xc_valid), 0);
    tick();
    for (int k = 0; k < 8; k++) ev[k] = 0;
    run_out("const");

    // Ramp, pushed back-to-back during the o_xc_last cycle
    push(-4);
    chk("b2b_valid", int'(o_xc_valid), 0);
    chk("b2b_xc", int'(o_xc), 0);
    chk("b2b_busy", int'(o_busy), 1);
    for (int k = -3; k <= 3; k++) push(k);
    give_ex(-1, 1);
    tick();
    for (int k = 0; k < 8; k++) ev[k] = k - 3;
    run_out("ramp");
    tick();

    // Extremes
    for (int k = 0; k < 4; k++) push(127);
    for (int k = 0; k < 4; k++) push(-127);
    give_ex(-127, 1);
    tick();
`ifdef IMP_XC_SAT8_EN
    for (int k = 0; k < 4; k++) ev[k] = 127;
`else
    for (int k = 0; k < 4; k++) ev[k] = 254;
`endif
    for (int k = 4; k < 8; k++) ev[k] = 0;
    run_out("ext");
    tick();

    // Early mean during FILL
    push(20); push(-20); push(5); push(0); push(100); push(-100);
    i_Ex_done = 1'b1; i_Ex = 9'd5;
    tick();
    i_Ex_done = 1'b0; i_Ex = 9'h1AA;
    chk("early_fill_rdy", int'(o_in_ready), 1);
    push(7); push(-8);
    chk("early_wait_valid", int'(o_xc_valid), 0);
    tick();
    chk("early_out_busy", int'(o_busy), 1);
    chk("early_out_valid", int'(o_xc_valid), 0);
    tick();
    ev[0] = 15; ev[1] = -25; ev[2] = 0; ev[3] = -5;
    ev[4] = 95; ev[5] = -105; ev[6] = 2; ev[7] = -13;
    run_out("early");
    tick();

    // Dropped input: hold i_valid with x=99 through WAIT and OUT
    for (int k = 1; k <= 8; k++) push(k);
    i_valid = 1'b1; i_x = 8'd99;
    tick();
    chk("drop_wait_rdy", int'(o_in_ready), 0);
    i_Ex_done = 1'b1; i_Ex = 9'd2;
    tick();
    i_Ex_done = 1'b0;
    chk("drop_out_rdy", int'(o_in_ready), 0);
    tick();
    for (int k = 0; k < 8; k++) ev[k] = k - 1;
    run_out("drop");
    tick();
    chk("drop_next_busy", int'(o_busy), 1);
    chk("drop_next_rdy", int'(o_in_ready), 1);
    for (int k = 0; k < 7; k++) tick();
    i_valid = 1'b0;
    chk("drop_next_wait", int'(o_in_ready), 0);
    give_ex(99, 1);
    tick();
    for (int k = 0; k < 8; k++) ev[k] = 0;
    run_out("drop2");
    tick();

    // Reset during OUT at rd_cnt=3
    for (int k = 30; k < 38; k++) push(k);
    give_ex(0, 1);
    tick();
    chk("rstm_xc0", int'($signed(o_xc)), 30);
    tick(); tick();
    chk("rstm_xc2", int'($signed(o_xc)), 32);
    i_rstn = 1'b0;
    #1;
    chk("rstm_valid", int'(o_xc_valid), 0);
    chk("rstm_xc", int'(o_xc), 0);
    chk("rstm_busy", int'(o_busy), 0);
    chk("rstm_rdy", int'(o_in_ready), 1);
    chk("rstm_last", int'(o_xc_last), 0);
    tick();
    i_rstn = 1'b1;
    tick();
    for (int k = 1; k <= 8; k++) push(k);
    give_ex(4, 1);
    tick();
    for (int k = 0; k < 8; k++) ev[k] = k - 3;
    run_out("post_rst");
    tick();
    chk("end_valid", int'(o_xc_valid), 0);
    chk("end_busy", int'(o_busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/imp_x_sub_ex_unit.md
Name: imp_x_sub_ex_unit

Overview:
Consumer end of the E[x] interface. Buffers the same N signed 8-bit samples fed to the mean unit, waits for the mean (i_Ex / i_Ex_done), then streams the centred values x_i − E[x] in arrival order. Sits between the input sample stream and the variance/normalise path of the LayerNorm datapath.

Parameters:
N, 8, samples per vector; power of two, ≥2; must match the mean unit's N.

Ports:
i_clk  input  1  clock
i_rstn  input  1  asynchronous active-low reset
i_valid  input  1  input sample strobe (same stream as the mean unit's i_valid)
i_x  input  8  signed sample, −127..127
o_in_ready  output  1  high when a sample can be accepted (IDLE or FILL)
i_Ex_done  input  1  one-cycle mean-valid pulse from the mean unit
i_Ex  input  9  signed mean; sampled only when i_Ex_done=1
o_xc_valid  output  1  centred output strobe
o_xc  output  9  signed x_i − Ex; 0 when o_xc_valid=0
o_xc_last  output  1  high with the N-th output of a vector
o_busy  output  1  high in any state other than IDLE

Behaviour:
- Interface: one clock, i_clk; reset i_rstn asynchronous, active-low. All state is registered, and all outputs come from registers.
- Reset values: state=IDLE, counters=0, ex_pend=0, ex_reg=0, o_xc_valid=0, o_xc=0, o_xc_last=0, o_busy=0, o_in_ready=1. Buffer contents are don't-care.
- Storage: N×8-bit buffer, write pointer wr_cnt and read pointer rd_cnt, each clog2(N) bits.
- States:
  - IDLE: o_in_ready=1. If i_valid, write buf[0], set wr_cnt=1, go to FILL.
  - FILL: o_in_ready=1. On i_valid, write buf[wr_cnt] and increment wr_cnt. When the N-th sample is written (wr_cnt==N−1 with i_valid), wrap wr_cnt to 0 and go to WAIT_EX. With no i_valid, hold.
  - WAIT_EX: o_in_ready=0. Leave for OUT when ex_pend=1 or i_Ex_done=1. On entry to OUT, use i_Ex if i_Ex_done=1, else ex_reg.
  - OUT: emit one result per cycle for N cycles, with rd_cnt = 0..N−1. Register o_xc = sign-extend(buf[rd_cnt]) − Ex and set o_xc_valid=1. Set o_xc_last=1 when rd_cnt==N−1. After the last one, clear ex_pend and go to IDLE.
- Mean capture: i_Ex_done in IDLE, FILL or WAIT_EX latches i_Ex into ex_reg and sets ex_pend=1. i_Ex_done during OUT is ignored; that case is a protocol error.
- Latency: first o_xc_valid is 1 cycle after the WAIT_EX→OUT transition. With the mean unit's 2-cycle turnaround, first output is 3 cycles after the N-th input.
- Arithmetic: 9-bit signed subtraction. Worst case is 127 − (−127) = 254 and −254, which fit in 9 bits with no overflow.
- i_valid while o_in_ready=0: the sample is dropped, and state, pointers and buffer are unchanged.
- Back-to-back vectors: IDLE accepts a new sample the cycle after o_xc_last.
- Reset mid-operation: return immediately to reset values, discard the partial vector and any pending mean.

Optional Feature:
IMP_XC_SAT8_EN
- Defined: o_xc is clamped to −127..127, so values >127 give 127 and values <−127 give −127. Bit 8 is still driven as the sign extension of the clamped value.
- Undefined: full 9-bit result, no clamp.

Test Plan:
- Constant vector, N=8, x=10 ×8, Ex=10 → eight outputs of 0; o_xc_last on the 8th; first output 3 cycles after the last input.
- Ramp x=−4..3, Ex=−1 (arithmetic shift of sum −4) → outputs −3,−2,−1,0,1,2,3,4 in order.
- Extremes, x=127 ×4 then −127 ×4, Ex=−127 → first four outputs 254 (127 with IMP_XC_SAT8_EN), last four 0.
- Early mean: i_Ex_done=1, i_Ex=5 pulsed during FILL after sample 6, then samples 7–8 → ex_pend set; OUT entered the cycle after sample 8; outputs are x_i−5.
- Dropped input: i_valid=1 during WAIT_EX and OUT with x=99 → no effect on outputs, o_in_ready=0 throughout; next vector starts the cycle after o_xc_last.
- Reset during OUT at rd_cnt=3 → all outputs 0 next edge, state IDLE, o_busy=0; a new vector then processes correctly.
